// File: rtl/tqvp_htfab_vga_capture.sv
`default_nettype none
// ============================================================================
// Module   : tqvp_htfab_vga_capture
// Purpose  : TinyQV peripheral that captures a monochrome VGA stream from the
//            input PMOD into a 32x16 one-bit frame buffer. The CPU reads one
//            32-bit word per row and gets a sticky frame-done interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module tqvp_htfab_vga_capture #(
  parameter int SYNC_NEG = 1,
  parameter int H_BACK   = 122,
  parameter int PIX_CLKS = 51,
  parameter int V_BACK   = 33,
  parameter int LINE_DIV = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ui_in,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  localparam logic [2:0]  c_IDLE   = 3'd0;
  localparam logic [2:0]  c_ARM    = 3'd1;
  localparam logic [2:0]  c_VBACK  = 3'd2;
  localparam logic [2:0]  c_ACTIVE = 3'd3;
  localparam logic [2:0]  c_DONE   = 3'd4;

  localparam logic        c_SYNC_NEG   = (SYNC_NEG != 0);
  // hc value of the first sample point (middle of logical pixel 0)
  localparam logic [12:0] c_HC_FIRST   = 13'(H_BACK + PIX_CLKS / 2);
  localparam logic [12:0] c_HC_STEP    = 13'(PIX_CLKS);
  localparam logic [8:0]  c_LINE_LAST  = 9'(16 * LINE_DIV - 1);
  localparam logic [8:0]  c_SUB_CAP    = 9'(LINE_DIV / 2);
  localparam logic [8:0]  c_SUB_LAST   = 9'(LINE_DIV - 1);
  localparam logic [8:0]  c_VBACK_LAST = 9'(V_BACK - 1);

  logic [2:0]  r_state;
  logic [2:0]  w_state_nx;
  logic        w_set_done;
  logic        r_continuous;
  logic        r_frame_done;
  logic        r_hs_d;
  logic        r_vs_d;
  logic [12:0] r_hc;
  logic [12:0] r_nx_hc;
  logic [5:0]  r_x;
  logic [31:0] r_ls;
  logic [8:0]  r_line;
  logic [8:0]  r_sub;
  logic [3:0]  r_row;
  logic [8:0]  r_vcnt;
  logic [31:0] r_rows [16];

  // Syncs normalised to active-high, and their edges against last cycle
  logic w_hs, w_vs, w_hs_lead, w_hs_trail, w_vs_lead, w_vs_trail;
  assign w_hs       = ui_in[7] ^ c_SYNC_NEG;
  assign w_vs       = ui_in[3] ^ c_SYNC_NEG;
  assign w_hs_lead  = w_hs & ~r_hs_d;
  assign w_hs_trail = ~w_hs & r_hs_d;
  assign w_vs_lead  = w_vs & ~r_vs_d;
  assign w_vs_trail = ~w_vs & r_vs_d;

  // Control byte decode
  logic w_byte_wr, w_arm, w_stop, w_clr;
  assign w_byte_wr = (data_write_n == 2'b00);
  assign w_arm     = w_byte_wr & data_in[0];
  assign w_clr     = w_byte_wr & data_in[2];
  assign w_stop    = w_byte_wr & data_in[3];

  // Row store happens on the hsync leading edge that closes a capture line
  logic w_row_wr;
  assign w_row_wr = (r_state == c_ACTIVE) && w_hs_lead && !w_vs_lead && !w_stop
                    && (r_sub == c_SUB_CAP);

  assign user_interrupt = r_frame_done;

  // Inputs that carry no meaning for this peripheral
  logic w_unused;
  assign w_unused = ^{ui_in[5:4], ui_in[2:0], address[1:0], data_in[31:4]};

  // Previous sync levels for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hs_d <= 1'b0;
      r_vs_d <= 1'b0;
    end else begin
      r_hs_d <= w_hs;
      r_vs_d <= w_vs;
    end
  end

  // Next-state logic; stop overrides every other transition
  always_comb begin
    w_state_nx = r_state;
    w_set_done = 1'b0;
    case (r_state)
      c_IDLE:   if (w_arm) w_state_nx = c_ARM;
      c_ARM:    if (w_vs_trail) w_state_nx = c_VBACK;
      c_VBACK: begin
        if (w_vs_lead) w_state_nx = c_ARM;
        else if (w_hs_trail && r_vcnt == c_VBACK_LAST) w_state_nx = c_ACTIVE;
      end
      c_ACTIVE: begin
        if (w_vs_lead) begin
          w_state_nx = c_ARM;
        end else if (w_hs_lead && r_line == c_LINE_LAST) begin
          w_state_nx = c_DONE;
          w_set_done = 1'b1;
        end
      end
      c_DONE:   w_state_nx = r_continuous ? c_ARM : c_IDLE;
      default:  w_state_nx = c_IDLE;
    endcase
    if (w_stop) begin
      w_state_nx = c_IDLE;
      w_set_done = 1'b0;
    end
  end

  // State, continuous-mode flag and sticky frame-done (set beats clear)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= c_IDLE;
      r_continuous <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      if (w_byte_wr) r_continuous <= data_in[1];
      if (w_set_done) r_frame_done <= 1'b1;
      else if (w_clr) r_frame_done <= 1'b0;
    end
  end

  // Back-porch line counter, only live while in VBACK
  always_ff @(posedge clk) begin
    if (rst || r_state != c_VBACK) r_vcnt <= '0;
    else if (w_hs_trail) r_vcnt <= r_vcnt + 9'd1;
  end

  // Line clock counter and pixel sampler; next sample point tracked incrementally
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hc    <= '0;
      r_nx_hc <= c_HC_FIRST;
      r_x     <= '0;
      r_ls    <= '0;
    end else if (w_hs_trail) begin
      r_hc    <= '0;
      r_nx_hc <= c_HC_FIRST;
      r_x     <= '0;
      r_ls    <= '0;
    end else begin
      if (r_hc != '1) r_hc <= r_hc + 13'd1;
      if (r_state == c_ACTIVE && !r_x[5] && r_hc == r_nx_hc) begin
        r_ls[r_x[4:0]] <= ui_in[6];
        r_x            <= r_x + 6'd1;
        r_nx_hc        <= r_nx_hc + c_HC_STEP;
      end
    end
  end

  // Line position: absolute line, line within row, and row index
  always_ff @(posedge clk) begin
    if (rst || r_state != c_ACTIVE) begin
      r_line <= '0;
      r_sub  <= '0;
      r_row  <= '0;
    end else if (w_hs_lead) begin
      r_line <= r_line + 9'd1;
      if (r_sub == c_SUB_LAST) begin
        r_sub <= '0;
        r_row <= r_row + 4'd1;
      end else begin
        r_sub <= r_sub + 9'd1;
      end
    end
  end

  // Frame buffer rows
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) r_rows[i] <= '0;
    end else if (w_row_wr) begin
      r_rows[r_row] <= r_ls;
    end
  end

  // Registered read port with a one-cycle ready pulse per request
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out   <= '0;
      data_ready <= 1'b0;
    end else if (data_read_n == 2'b10) begin
      data_out   <= r_rows[address[5:2]];
      data_ready <= 1'b1;
    end else if (data_read_n == 2'b00) begin
      data_out   <= {28'b0, (r_state == c_ACTIVE), (r_state != c_IDLE),
                     r_continuous, r_frame_done};
      data_ready <= 1'b1;
    end else begin
      data_ready <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tqvp_htfab_vga_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_tqvp_htfab_vga_capture
// Purpose  : Self-checking bench for the VGA capture peripheral. A VGA frame
//            generator drives the PMOD; a row-level model predicts the image.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tqvp_htfab_vga_capture;

  localparam int H_BACK    = 3;
  localparam int PIX       = 4;
  localparam int V_BACK    = 2;
  localparam int LD        = 2;
  localparam int LINE      = 140;
  localparam int HS_W      = 5;
  localparam int SHORT_LEN = HS_W + 1 + H_BACK + 10 * PIX;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ui_in;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;

  logic [31:0] exp_rows [16];
  int          n_checks = 0;
  int          n_pass   = 0;

  tqvp_htfab_vga_capture #(
    .SYNC_NEG(1), .H_BACK(H_BACK), .PIX_CLKS(PIX), .V_BACK(V_BACK), .LINE_DIV(LD)
  ) dut (
    .clk(clk), .rst(rst), .ui_in(ui_in), .address(address), .data_in(data_in),
    .data_write_n(data_write_n), .data_read_n(data_read_n), .data_out(data_out),
    .data_ready(data_ready), .user_interrupt(user_interrupt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pixels whose sample point falls before the line's closing hsync edge
  function automatic logic [31:0] line_mask(input int len);
    logic [31:0] m = '0;
    for (int x = 0; x < 32; x++)
      if (H_BACK + x * PIX + PIX / 2 < len - HS_W - 1) m[x] = 1'b1;
    return m;
  endfunction

  // One raw VGA line: active-low hsync pulse first, pixel x held for PIX clocks
  task automatic drive_line(input logic [31:0] pat, input int len, input int vs_from);
    for (int c = 0; c < len; c++) begin
      int x;
      x = c - (HS_W + 1 + H_BACK);
      ui_in[7] = (c < HS_W) ? 1'b0 : 1'b1;
      ui_in[3] = (c >= vs_from) ? 1'b0 : 1'b1;
      ui_in[6] = (x >= 0 && x < 32 * PIX) ? pat[x / PIX] : 1'b0;
      tick();
    end
  endtask

  // Full frame: vsync, back porch, 16*LD active lines, one closing porch line
  task automatic drive_frame(input int abort_line, input int short_line,
                             input bit upd, input bit fixed);
    logic [31:0] pat;
    int          len;
    int          r;
    for (int i = 0; i < 2; i++) drive_line($urandom, LINE, 0);
    for (int i = 0; i < V_BACK - 1; i++) drive_line($urandom, LINE, LINE);
    for (int l = 0; l < 16 * LD; l++) begin
      r   = l / LD;
      pat = $urandom;
      if (fixed && (l % LD == LD / 2)) pat = (32'd1 << r) | (32'd1 << (2 * r + 1));
      if (l == short_line) pat = '1;
      len = (l == short_line) ? SHORT_LEN : LINE;
      if (l == abort_line) begin
        drive_line(pat, LINE, LINE / 2);
        drive_line($urandom, LINE, 0);
        return;
      end
      drive_line(pat, len, LINE);
      if (upd && (l % LD == LD / 2)) exp_rows[r] = pat & line_mask(len);
    end
    drive_line($urandom, LINE, LINE);
  endtask

  task automatic bus_read(input logic [5:0] addr, input logic [1:0] rn,
                          input logic [31:0] exp, input string tag);
    address     = addr;
    data_read_n = rn;
    tick();
    address     = 6'($urandom);
    data_read_n = 2'b11;
    check({tag, "_rdy"}, {31'b0, data_ready}, 32'd1);
    check(tag, data_out, exp);
    tick();
    check({tag, "_rdy_drop"}, {31'b0, data_ready}, 32'd0);
  endtask

  task automatic status(input logic [3:0] exp, input string tag);
    bus_read(6'($urandom), 2'b00, {28'b0, exp}, tag);
  endtask

  task automatic wr_byte(input logic [3:0] v);
    data_in      = {28'($urandom), v};
    data_write_n = 2'b00;
    tick();
    data_write_n = 2'b11;
    data_in      = $urandom;
  endtask

  task automatic check_rows(input string tag);
    for (int r = 0; r < 16; r++)
      bus_read({4'(r), 2'($urandom)}, 2'b10, exp_rows[r], $sformatf("%s_row%0d", tag, r));
  endtask

  initial begin
    rst          = 1'b1;
    ui_in        = 8'h88;
    address      = '0;
    data_in      = '0;
    data_write_n = 2'b11;
    data_read_n  = 2'b11;
    for (int i = 0; i < 16; i++) exp_rows[i] = '0;
    repeat (3) tick();
    check("rst_irq", {31'b0, user_interrupt}, 32'd0);
    check("rst_rdy", {31'b0, data_ready}, 32'd0);
    check("rst_dout", data_out, 32'd0);
    rst = 1'b0;
    tick();
    status(4'h0, "rst_status");
    check_rows("rst");

    // Single capture with the diagonal pattern
    wr_byte(4'h1);
    status(4'h4, "t1_armed");
    drive_frame(-1, -1, 1'b1, 1'b1);
    check("t1_irq", {31'b0, user_interrupt}, 32'd1);
    status(4'h1, "t1_status");
    check_rows("t1");
    bus_read(6'h14, 2'b10, 32'h0000_0800 | 32'h0000_0020, "t2_row5");

    // Word and halfword accesses are ignored
    data_in = 32'h0000_0003; data_write_n = 2'b10; tick();
    data_in = 32'h0000_0004; data_write_n = 2'b01; tick();
    data_write_n = 2'b11;
    data_read_n = 2'b01; tick();
    check("half_read_rdy", {31'b0, data_ready}, 32'd0);
    data_read_n = 2'b11;
    status(4'h1, "ignored_status");

    // Short line on active line 5 (row 2)
    wr_byte(4'h5);
    check("t3_irq_clr", {31'b0, user_interrupt}, 32'd0);
    drive_frame(-1, 5, 1'b1, 1'b0);
    bus_read(6'h08, 2'b10, 32'h0000_03FF, "t3_short");
    check_rows("t3");

    // Abort during active line 9, then a clean frame
    wr_byte(4'h5);
    drive_frame(9, -1, 1'b1, 1'b0);
    check("t4_irq", {31'b0, user_interrupt}, 32'd0);
    status(4'h4, "t4_arm");
    check_rows("t4_abort");
    drive_frame(-1, -1, 1'b1, 1'b0);
    check("t4_irq_done", {31'b0, user_interrupt}, 32'd1);
    status(4'h1, "t4_status");
    check_rows("t4");

    // Continuous mode, clear mid-frame
    wr_byte(4'h4);
    wr_byte(4'h3);
    status(4'h6, "t5_armed");
    fork
      drive_frame(-1, -1, 1'b1, 1'b0);
      begin
        repeat (10 * LINE) tick();
        status(4'hE, "t5_active1");
      end
    join
    check("t5_irq1", {31'b0, user_interrupt}, 32'd1);
    status(4'h7, "t5_rearm");
    fork
      drive_frame(-1, -1, 1'b1, 1'b0);
      begin
        repeat (10 * LINE) tick();
        status(4'hF, "t5_active2");
        check("t5_irq_pre", {31'b0, user_interrupt}, 32'd1);
        wr_byte(4'h4);
        check("t5_irq_fall", {31'b0, user_interrupt}, 32'd0);
        status(4'hC, "t5_after_clr");
      end
    join
    check("t5_irq2", {31'b0, user_interrupt}, 32'd1);
    status(4'h1, "t5_end");
    check_rows("t5");

    // Reset in the middle of a capture
    wr_byte(4'h1);
    fork
      drive_frame(-1, -1, 1'b0, 1'b0);
      begin
        repeat (20 * LINE) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_irq", {31'b0, user_interrupt}, 32'd0);
        check("t6_rst_rdy", {31'b0, data_ready}, 32'd0);
        check("t6_rst_dout", data_out, 32'd0);
        status(4'h0, "t6_rst_status");
      end
    join
    for (int i = 0; i < 16; i++) exp_rows[i] = '0;
    check_rows("t6_rst");

    // Stop mid-frame
    wr_byte(4'h1);
    fork
      drive_frame(-1, -1, 1'b0, 1'b0);
      begin
        repeat (12 * LINE) tick();
        status(4'hC, "t6_active");
        wr_byte(4'h8);
        status(4'h0, "t6_stop");
      end
    join
    status(4'h0, "t6_idle");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
